// File: rtl/mor1kx_tlb_reload_walker_port_pkg.sv
// Shared encodings for the TLB-reload walker port: FSM states, Wishbone constants, error data.
// No logic; constants only.
package mor1kx_tlb_reload_walker_port_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUS   = 2'd1;
    localparam logic [1:0] ST_RETRY = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    localparam logic [31:0] TLB_RELOAD_ERR_DATA = 32'h0000_0000;

endpackage

// File: rtl/mor1kx_tlb_reload_walker_port.sv
// Single-word Wishbone classic read per MMU TLB-reload request; optional bus timeout via MOR1KX_TLB_RELOAD_TIMEOUT_EN.
// Latency: req sampled in IDLE -> ack pulse after 2 edges with a zero-wait slave (ack seen on 3rd edge).
// Backpressure: slave stalls by withholding termination; requester holds req level, may drop it to abort.
module mor1kx_tlb_reload_walker_port
    import mor1kx_tlb_reload_walker_port_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_TLB_RELOAD_TIMEOUT = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            tlb_reload_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] tlb_reload_addr_i,
    output logic                            tlb_reload_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] tlb_reload_data_o,
    output logic                            bus_error_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
    output logic                            wbm_stb_o,
    output logic                            wbm_cyc_o,
    output logic                            wbm_we_o,
    output logic [3:0]                      wbm_sel_o,
    output logic [2:0]                      wbm_cti_o,
    output logic [1:0]                      wbm_bte_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
    input  logic                            wbm_ack_i,
    input  logic                            wbm_err_i,
    input  logic                            wbm_rty_i
);

    logic [1:0] state;
    logic       cyc_q;
    logic       term_ack;
    logic       term_err;
    logic       term_rty;
    logic       timeout;
    logic       addr_lo_unused;

    assign addr_lo_unused = ^tlb_reload_addr_i[1:0];

`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
    localparam int CNT_W = ($clog2(OPTION_TLB_RELOAD_TIMEOUT + 1) > 8) ?
                           $clog2(OPTION_TLB_RELOAD_TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt;

    // Cleared only when a fresh fetch starts, so retries share one budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_IDLE && tlb_reload_req_i) begin
            tmo_cnt <= '0;
        end else if (state == ST_BUS) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign timeout = (tmo_cnt == CNT_W'(OPTION_TLB_RELOAD_TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    // Termination inputs only matter while a cycle is on the bus; ack wins over err, err over rty.
    always_comb begin
        term_ack = 1'b0;
        term_err = 1'b0;
        term_rty = 1'b0;
        if (state == ST_BUS) begin
            term_ack = wbm_ack_i;
            term_err = !wbm_ack_i && wbm_err_i;
            term_rty = !wbm_ack_i && !wbm_err_i && wbm_rty_i;
            if (!wbm_ack_i && !wbm_err_i && !wbm_rty_i && timeout) begin
                term_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            cyc_q             <= 1'b0;
            wbm_adr_o         <= '0;
            tlb_reload_data_o <= '0;
            bus_error_o       <= 1'b0;
        end else begin
            bus_error_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tlb_reload_req_i) begin
                        wbm_adr_o <= {tlb_reload_addr_i[OPTION_OPERAND_WIDTH-1:2], 2'b00};
                        cyc_q     <= 1'b1;
                        state     <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (term_ack) begin
                        tlb_reload_data_o <= wbm_dat_i;
                        cyc_q             <= 1'b0;
                        state             <= tlb_reload_req_i ? ST_RESP : ST_IDLE;
                    end else if (term_err) begin
                        tlb_reload_data_o <= OPTION_OPERAND_WIDTH'(TLB_RELOAD_ERR_DATA);
                        bus_error_o       <= 1'b1;
                        cyc_q             <= 1'b0;
                        state             <= tlb_reload_req_i ? ST_RESP : ST_IDLE;
                    end else if (term_rty) begin
                        cyc_q <= 1'b0;
                        state <= ST_RETRY;
                    end
                end
                ST_RETRY: begin
                    cyc_q <= 1'b1;
                    state <= ST_BUS;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    cyc_q <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tlb_reload_ack_o = (state == ST_RESP);
    assign wbm_cyc_o        = cyc_q;
    assign wbm_stb_o        = cyc_q;
    assign wbm_we_o         = 1'b0;
    assign wbm_sel_o        = 4'hf;
    assign wbm_cti_o        = CTI_CLASSIC;
    assign wbm_bte_o        = BTE_LINEAR;

endmodule

// File: tb/tb_mor1kx_tlb_reload_walker_port.sv
// Directed bench for the TLB-reload walker port: reset, fetch, walk, error, retry, abort, timeout.
module tb_mor1kx_tlb_reload_walker_port;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req = 1'b0;
    logic [W-1:0] addr = '0;
    logic         ack_o;
    logic [W-1:0] data_o;
    logic         bus_err;
    logic [W-1:0] adr;
    logic         stb, cyc, we;
    logic [3:0]   sel;
    logic [2:0]   cti;
    logic [1:0]   bte;
    logic [W-1:0] dat_i = '0;
    logic         ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;

    int vecs = 0;
    int errs = 0;
    int ack_cnt = 0;

    mor1kx_tlb_reload_walker_port #(
        .OPTION_OPERAND_WIDTH(W),
        .OPTION_TLB_RELOAD_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .tlb_reload_req_i(req), .tlb_reload_addr_i(addr),
        .tlb_reload_ack_o(ack_o), .tlb_reload_data_o(data_o),
        .bus_error_o(bus_err),
        .wbm_adr_o(adr), .wbm_stb_o(stb), .wbm_cyc_o(cyc), .wbm_we_o(we),
        .wbm_sel_o(sel), .wbm_cti_o(cti), .wbm_bte_o(bte),
        .wbm_dat_i(dat_i), .wbm_ack_i(ack_i), .wbm_err_i(err_i), .wbm_rty_i(rty_i)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && ack_o) ack_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        vecs++; if (cyc !== 1'b0) begin errs++; $display("FAIL reset_cyc got %b want 0", cyc); end
        vecs++; if (stb !== 1'b0) begin errs++; $display("FAIL reset_stb got %b want 0", stb); end
        vecs++; if (ack_o !== 1'b0) begin errs++; $display("FAIL reset_ack got %b want 0", ack_o); end
        vecs++; if (data_o !== 32'h0) begin errs++; $display("FAIL reset_data got %h want 0", data_o); end
        vecs++; if (bus_err !== 1'b0) begin errs++; $display("FAIL reset_buserr got %b want 0", bus_err); end
        vecs++; if (adr !== 32'h0) begin errs++; $display("FAIL reset_adr got %h want 0", adr); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        int a0;
        a0 = ack_cnt;
        req = 1'b1; addr = 32'h0000_1236;
        tick();
        vecs++; if (cyc !== 1'b1 || stb !== 1'b1) begin errs++; $display("FAIL single_cycstb got %b%b want 11", cyc, stb); end
        vecs++; if (adr !== 32'h0000_1234) begin errs++; $display("FAIL single_adr got %h want 00001234", adr); end
        vecs++; if (sel !== 4'hf || we !== 1'b0 || cti !== 3'b000 || bte !== 2'b00)
            begin errs++; $display("FAIL single_ctrl got sel=%h we=%b cti=%b bte=%b want f 0 000 00", sel, we, cti, bte); end
        repeat (2) begin
            tick();
            vecs++; if (cyc !== 1'b1 || ack_o !== 1'b0) begin errs++; $display("FAIL single_wait got cyc=%b ack=%b want 1 0", cyc, ack_o); end
        end
        ack_i = 1'b1; dat_i = 32'h8000_2403;
        tick();
        ack_i = 1'b0; dat_i = 32'hDEAD_BEEF;
        vecs++; if (ack_o !== 1'b1) begin errs++; $display("FAIL single_ack got %b want 1", ack_o); end
        vecs++; if (data_o !== 32'h8000_2403) begin errs++; $display("FAIL single_data got %h want 80002403", data_o); end
        vecs++; if (cyc !== 1'b0) begin errs++; $display("FAIL single_cycdrop got %b want 0", cyc); end
        req = 1'b0;
        tick();
        vecs++; if (ack_o !== 1'b0 || data_o !== 32'h8000_2403)
            begin errs++; $display("FAIL single_hold got ack=%b data=%h want 0 80002403", ack_o, data_o); end
        vecs++; if (ack_cnt - a0 !== 1) begin errs++; $display("FAIL single_ackcount got %0d want 1", ack_cnt - a0); end
    endtask

    task automatic test_two_level_walk();
        int a0;
        a0 = ack_cnt;
        req = 1'b1; addr = 32'h0000_3008;
        tick();
        ack_i = 1'b1; dat_i = 32'h8000_2001;
        tick();
        ack_i = 1'b0;
        vecs++; if (ack_o !== 1'b1 || data_o !== 32'h8000_2001)
            begin errs++; $display("FAIL walk_first got ack=%b data=%h want 1 80002001", ack_o, data_o); end
        addr = 32'h8000_2018;
        tick();
        vecs++; if (ack_o !== 1'b0 || cyc !== 1'b0) begin errs++; $display("FAIL walk_idle got ack=%b cyc=%b want 0 0", ack_o, cyc); end
        tick();
        vecs++; if (cyc !== 1'b1 || adr !== 32'h8000_2018)
            begin errs++; $display("FAIL walk_second_adr got cyc=%b adr=%h want 1 80002018", cyc, adr); end
        ack_i = 1'b1; dat_i = 32'h0ABC_D00F;
        tick();
        ack_i = 1'b0; req = 1'b0;
        vecs++; if (ack_o !== 1'b1 || data_o !== 32'h0ABC_D00F)
            begin errs++; $display("FAIL walk_second got ack=%b data=%h want 1 0abcd00f", ack_o, data_o); end
        tick();
        vecs++; if (ack_cnt - a0 !== 2) begin errs++; $display("FAIL walk_ackcount got %0d want 2", ack_cnt - a0); end
    endtask

    task automatic test_error();
        req = 1'b1; addr = 32'h0000_4000;
        tick();
        err_i = 1'b1; dat_i = 32'h1234_5678;
        tick();
        err_i = 1'b0;
        vecs++; if (ack_o !== 1'b1 || data_o !== 32'h0 || bus_err !== 1'b1)
            begin errs++; $display("FAIL err_resp got ack=%b data=%h buserr=%b want 1 0 1", ack_o, data_o, bus_err); end
        vecs++; if (cyc !== 1'b0) begin errs++; $display("FAIL err_cyc got %b want 0", cyc); end
        req = 1'b0;
        tick();
        vecs++; if (bus_err !== 1'b0 || cyc !== 1'b0) begin errs++; $display("FAIL err_after got buserr=%b cyc=%b want 0 0", bus_err, cyc); end
        // ack and err together: ack wins
        req = 1'b1;
        tick();
        ack_i = 1'b1; err_i = 1'b1; dat_i = 32'h5555_0004;
        tick();
        ack_i = 1'b0; err_i = 1'b0; req = 1'b0;
        vecs++; if (ack_o !== 1'b1 || data_o !== 32'h5555_0004 || bus_err !== 1'b0)
            begin errs++; $display("FAIL ackerr_prio got ack=%b data=%h buserr=%b want 1 55550004 0", ack_o, data_o, bus_err); end
        tick();
    endtask

    task automatic test_retry();
        int a0;
        a0 = ack_cnt;
        req = 1'b1; addr = 32'h0000_0042;
        tick();
        for (int k = 0; k < 2; k++) begin
            rty_i = 1'b1;
            tick();
            rty_i = 1'b0;
            vecs++; if (cyc !== 1'b0) begin errs++; $display("FAIL retry_gap%0d got cyc=%b want 0", k, cyc); end
            tick();
            vecs++; if (cyc !== 1'b1 || adr !== 32'h0000_0040)
                begin errs++; $display("FAIL retry_reissue%0d got cyc=%b adr=%h want 1 00000040", k, cyc, adr); end
        end
        ack_i = 1'b1; dat_i = 32'hA5A5_A400;
        tick();
        ack_i = 1'b0; req = 1'b0;
        vecs++; if (ack_o !== 1'b1 || data_o !== 32'hA5A5_A400)
            begin errs++; $display("FAIL retry_resp got ack=%b data=%h want 1 a5a5a400", ack_o, data_o); end
        tick();
        vecs++; if (ack_cnt - a0 !== 1) begin errs++; $display("FAIL retry_ackcount got %0d want 1", ack_cnt - a0); end
    endtask

    task automatic test_abort();
        int a0;
        a0 = ack_cnt;
        req = 1'b1; addr = 32'h0000_5000;
        tick();
        tick();
        req = 1'b0;
        repeat (3) begin
            tick();
            vecs++; if (cyc !== 1'b1) begin errs++; $display("FAIL abort_hold got cyc=%b want 1", cyc); end
        end
        ack_i = 1'b1; dat_i = 32'h0000_0777;
        tick();
        ack_i = 1'b0;
        vecs++; if (cyc !== 1'b0 || ack_o !== 1'b0) begin errs++; $display("FAIL abort_end got cyc=%b ack=%b want 0 0", cyc, ack_o); end
        tick();
        vecs++; if (cyc !== 1'b0 || ack_o !== 1'b0) begin errs++; $display("FAIL abort_idle got cyc=%b ack=%b want 0 0", cyc, ack_o); end
        vecs++; if (ack_cnt - a0 !== 0) begin errs++; $display("FAIL abort_ackcount got %0d want 0", ack_cnt - a0); end
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        req = 1'b1; addr = 32'h0000_6000;
        tick();
`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
        while (cyc === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        vecs++; if (n !== 16) begin errs++; $display("FAIL timeout_cycles got %0d want 16", n); end
        vecs++; if (ack_o !== 1'b1 || data_o !== 32'h0 || bus_err !== 1'b1)
            begin errs++; $display("FAIL timeout_resp got ack=%b data=%h buserr=%b want 1 0 1", ack_o, data_o, bus_err); end
        req = 1'b0;
        tick();
`else
        for (int k = 0; k < 1000; k++) begin
            if (cyc === 1'b1) n++;
            tick();
        end
        vecs++; if (n !== 1000) begin errs++; $display("FAIL notimeout_hold got %0d want 1000", n); end
        // Asynchronous reset truncates the stuck cycle immediately.
        #2 rst_n = 1'b0;
        #1;
        vecs++; if (cyc !== 1'b0 || stb !== 1'b0) begin errs++; $display("FAIL async_reset got cyc=%b stb=%b want 0 0", cyc, stb); end
        req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`endif
        vecs++; if (cyc !== 1'b0) begin errs++; $display("FAIL timeout_idle got cyc=%b want 0", cyc); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_two_level_walk();
        test_error();
        test_retry();
        test_abort();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
